// File: rtl/ice_cmd_pkg.sv
// ice_cmd_pkg: shared encodings for the host->ICE command path.
// Parser states, error codes and known command-type bytes.
package ice_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVT,
    ST_LEN,
    ST_PAYLOAD,
    ST_DISPATCH
  } state_e;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_OVERRUN  = 2'd1;
  localparam logic [1:0] ERR_UNK_TYPE = 2'd2;

  localparam logic [7:0] CMD_QUERY   = 8'h3f;
  localparam logic [7:0] CMD_VER_UP  = 8'h56;
  localparam logic [7:0] CMD_MBUS_B  = 8'h62;
  localparam logic [7:0] CMD_MBUS_M  = 8'h6d;
  localparam logic [7:0] CMD_GOC     = 8'h6f;
  localparam logic [7:0] CMD_PMU     = 8'h70;
  localparam logic [7:0] CMD_VER     = 8'h76;

  function automatic logic is_known_type(input logic [7:0] t);
    return (t == CMD_QUERY)  || (t == CMD_VER_UP) ||
           (t == CMD_MBUS_B) || (t == CMD_MBUS_M) ||
           (t == CMD_GOC)    || (t == CMD_PMU)    ||
           (t == CMD_VER);
  endfunction

endpackage

// File: rtl/ice_cmd_parser_if.sv
// ice_cmd_parser_if: command handoff from parser to dispatcher.
// Valid/ready transfer plus the payload read port.
interface ice_cmd_parser_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_type;
  logic [7:0] cmd_event_id;
  logic [7:0] cmd_len;
  logic [7:0] pl_rd_addr;
  logic [7:0] pl_rd_data;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_event_id,
    output cmd_len,
    output pl_rd_data,
    input  cmd_ready,
    input  pl_rd_addr
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_event_id,
    input  cmd_len,
    input  pl_rd_data,
    output cmd_ready,
    output pl_rd_addr
  );
endinterface

// File: rtl/ice_cmd_buf.sv
// ice_cmd_buf: 2^AW x 8 simple dual-port payload RAM.
// One write port, one registered read port.
module ice_cmd_buf #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem_q [0:(1<<AW)-1];
  logic [7:0] rd_d;
  logic [7:0] rd_q;

  assign rd_d = mem_q[ra];
  assign rd   = rd_q;

  // Write port: no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
  end

  // Registered read data, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/ice_cmd_parser.sv
// ice_cmd_parser: deframes [type][id][len][payload] host commands.
// Optional type filter: define ICE_CMD_TYPE_FILTER_EN.
module ice_cmd_parser
  import ice_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned BUF_AW         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_latch,
  input  logic [7:0]       rx_data,
  ice_cmd_parser_if.master cmd_if,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [7:0]       err_event_id,
  output logic             busy
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          lat_q, lat_d;
  logic [7:0]    type_q, type_d;
  logic [7:0]    evt_q, evt_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic          err_v_q, err_v_d;
  logic [1:0]    err_c_q, err_c_d;
  logic [7:0]    err_id_q, err_id_d;
  logic          busy_q, busy_d;

  logic stb;
  logic xfer;
  logic in_frame;
  logic tmo_hit;
  logic sof;
  logic ovr;
  logic evt_b;
  logic len_b;
  logic pay_b;
  logic fin;
  logic wr_en;
  logic type_ok;

`ifdef ICE_CMD_TYPE_FILTER_EN
  logic known_q, known_d;
  assign type_ok = known_q;
`else
  assign type_ok = 1'b1;
`endif

  assign lat_d    = rx_latch;
  assign stb      = rx_latch & ~lat_q;
  assign xfer     = valid_q & cmd_if.cmd_ready;
  assign in_frame = (state_q == ST_EVT) ||
                    (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD);
  assign tmo_hit  = in_frame && (tmo_q == T_LAST);
  assign sof      = stb && ((state_q == ST_IDLE) || xfer);
  assign ovr      = stb && (state_q == ST_DISPATCH) && !xfer;
  assign evt_b    = stb && !tmo_hit && (state_q == ST_EVT);
  assign len_b    = stb && !tmo_hit && (state_q == ST_LEN);
  assign pay_b    = stb && !tmo_hit && (state_q == ST_PAYLOAD);

  // Next-state, capture, timeout and error selection.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    evt_d    = evt_q;
    len_d    = len_q;
    wr_idx_d = wr_idx_q;
    tmo_d    = '0;
    valid_d  = valid_q;
    err_v_d  = 1'b0;
    err_c_d  = err_c_q;
    err_id_d = err_id_q;
    wr_en    = 1'b0;
    fin      = 1'b0;
`ifdef ICE_CMD_TYPE_FILTER_EN
    known_d  = known_q;
`endif

    if (in_frame && !stb && !tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (xfer) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end

    unique case (1'b1)
      tmo_hit: begin
        err_v_d  = 1'b1;
        err_c_d  = ERR_TIMEOUT;
        err_id_d = evt_q;
        state_d  = ST_IDLE;
      end
      sof: begin
        type_d  = rx_data;
        evt_d   = '0;
        state_d = ST_EVT;
`ifdef ICE_CMD_TYPE_FILTER_EN
        known_d = is_known_type(rx_data);
`endif
      end
      ovr: begin
        err_v_d  = 1'b1;
        err_c_d  = ERR_OVERRUN;
        err_id_d = evt_q;
      end
      evt_b: begin
        evt_d   = rx_data;
        state_d = ST_LEN;
      end
      len_b: begin
        len_d    = rx_data;
        wr_idx_d = '0;
        if (rx_data == 8'd0) begin
          fin = 1'b1;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      pay_b: begin
        wr_en    = type_ok;
        wr_idx_d = wr_idx_q + 8'd1;
        if (wr_idx_q == len_q - 8'd1) begin
          fin = 1'b1;
        end
      end
      default: ;
    endcase

    if (fin) begin
      if (type_ok) begin
        state_d = ST_DISPATCH;
        valid_d = 1'b1;
      end else begin
        err_v_d  = 1'b1;
        err_c_d  = ERR_UNK_TYPE;
        err_id_d = evt_q;
        state_d  = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk) begin
    lat_q <= lat_d;
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      evt_q    <= '0;
      len_q    <= '0;
      wr_idx_q <= '0;
      tmo_q    <= '0;
      valid_q  <= 1'b0;
      err_v_q  <= 1'b0;
      err_c_q  <= '0;
      err_id_q <= '0;
      busy_q   <= 1'b0;
`ifdef ICE_CMD_TYPE_FILTER_EN
      known_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      evt_q    <= evt_d;
      len_q    <= len_d;
      wr_idx_q <= wr_idx_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      err_v_q  <= err_v_d;
      err_c_q  <= err_c_d;
      err_id_q <= err_id_d;
      busy_q   <= busy_d;
`ifdef ICE_CMD_TYPE_FILTER_EN
      known_q  <= known_d;
`endif
    end
  end

  ice_cmd_buf #(
    .AW (BUF_AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .wa    (BUF_AW'(wr_idx_q)),
    .wd    (rx_data),
    .ra    (BUF_AW'(cmd_if.pl_rd_addr)),
    .rd    (cmd_if.pl_rd_data)
  );

  assign cmd_if.cmd_valid    = valid_q;
  assign cmd_if.cmd_type     = type_q;
  assign cmd_if.cmd_event_id = evt_q;
  assign cmd_if.cmd_len      = len_q;
  assign err_valid           = err_v_q;
  assign err_code            = err_c_q;
  assign err_event_id        = err_id_q;
  assign busy                = busy_q;

endmodule
